// File: rtl/dut_emul_pkg.sv
// Shared defaults and FSM state type for the DUT configuration-chain emulator.
package dut_emul_pkg;

  localparam int unsigned CFG_WIDTH_DEFAULT   = 256;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/dut_config_chain_emulator_if.sv
// Pin-side bundle of the config-chain emulator: DUT config pins in, status out.
interface dut_config_chain_emulator_if #(
  parameter int unsigned CFG_WIDTH = dut_emul_pkg::CFG_WIDTH_DEFAULT
);

  logic                 config_clk;
  logic                 reset_not;
  logic                 config_in;
  logic                 config_load;
  logic                 config_out;
  logic [CFG_WIDTH-1:0] config_shadow;
  logic                 load_pulse;
  logic [15:0]          load_count;
  logic                 length_error;
  logic [1:0]           state;

  modport master (
    output config_clk, reset_not, config_in, config_load,
    input  config_out, config_shadow, load_pulse, load_count, length_error, state
  );

  modport slave (
    input  config_clk, reset_not, config_in, config_load,
    output config_out, config_shadow, load_pulse, load_count, length_error, state
  );

endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dut_config_chain_emulator.sv
// Emulates a DUT configuration shift chain driven from asynchronous FPGA pins:
// synchronizes the pins, shifts on config_clk rises and latches a shadow on config_load.
module dut_config_chain_emulator
  import dut_emul_pkg::*;
#(
  parameter int unsigned CFG_WIDTH   = CFG_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic                        S_AXI_ACLK,
  input logic                        S_AXI_ARESETN,
  dut_config_chain_emulator_if.slave pins
);

  localparam int unsigned CntW = $clog2(CFG_WIDTH + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(CFG_WIDTH);
  localparam logic [CntW-1:0] CntSat  = CntW'(CFG_WIDTH + 1);

  localparam int unsigned PinClk  = 0;
  localparam int unsigned PinRst  = 1;
  localparam int unsigned PinIn   = 2;
  localparam int unsigned PinLoad = 3;

  logic [3:0] pin_raw;
  logic [3:0] pin_sync;

  assign pin_raw = {pins.config_load, pins.config_in, pins.reset_not, pins.config_clk};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    cdc_sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (S_AXI_ACLK),
      .rst_ni(S_AXI_ARESETN),
      .d_i   (pin_raw[i]),
      .q_o   (pin_sync[i])
    );
  end

  logic                 clk_hist_q, load_hist_q;
  logic                 chain_run, shift_edge, load_edge;
  logic [CFG_WIDTH-1:0] sr_q, sr_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]          load_count_q, load_count_d;
  logic                 length_error_q, length_error_d;
  logic                 load_pulse_q;
  state_e               state_q, state_d;

  // Edges are swallowed while the DUT reset pin is held low.
  assign chain_run  = pin_sync[PinRst];
  assign shift_edge = chain_run & pin_sync[PinClk] & ~clk_hist_q;
  assign load_edge  = chain_run & pin_sync[PinLoad] & ~load_hist_q;

  always_comb begin
    sr_d           = sr_q;
    shadow_d       = shadow_q;
    bit_cnt_d      = bit_cnt_q;
    load_count_d   = load_count_q;
    length_error_d = length_error_q;
    state_d        = state_q;
    if (!chain_run) begin
      sr_d           = '0;
      shadow_d       = '0;
      bit_cnt_d      = '0;
      length_error_d = 1'b0;
      state_d        = IDLE;
    end else begin
      if (shift_edge) begin
        sr_d = {sr_q[CFG_WIDTH-2:0], pin_sync[PinIn]};
        if (bit_cnt_q != CntSat) begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        state_d = (bit_cnt_d >= CntFull) ? FULL : SHIFT;
      end
      // A load in the same cycle as a shift sees the pre-shift register and count.
      if (load_edge) begin
        shadow_d  = sr_q;
        bit_cnt_d = '0;
        state_d   = IDLE;
        if (bit_cnt_q != CntFull) begin
          length_error_d = 1'b1;
        end
        if (load_count_q != 16'hFFFF) begin
          load_count_d = load_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      clk_hist_q     <= 1'b0;
      load_hist_q    <= 1'b0;
      sr_q           <= '0;
      shadow_q       <= '0;
      bit_cnt_q      <= '0;
      load_count_q   <= '0;
      length_error_q <= 1'b0;
      load_pulse_q   <= 1'b0;
      state_q        <= IDLE;
    end else begin
      clk_hist_q     <= pin_sync[PinClk];
      load_hist_q    <= pin_sync[PinLoad];
      sr_q           <= sr_d;
      shadow_q       <= shadow_d;
      bit_cnt_q      <= bit_cnt_d;
      load_count_q   <= load_count_d;
      length_error_q <= length_error_d;
      load_pulse_q   <= load_edge;
      state_q        <= state_d;
    end
  end

  assign pins.config_out    = sr_q[CFG_WIDTH-1];
  assign pins.config_shadow = shadow_q;
  assign pins.load_pulse    = load_pulse_q;
  assign pins.load_count    = load_count_q;
  assign pins.length_error  = length_error_q;
  assign pins.state         = state_q;

endmodule

// File: tb/tb_dut_config_chain_emulator.sv
// Randomized bench for the config-chain emulator at CFG_WIDTH=8 against a frame-level model.
module tb_dut_config_chain_emulator;

  localparam int W = 8;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  dut_config_chain_emulator_if #(.CFG_WIDTH(W)) pins ();

  dut_config_chain_emulator #(
    .CFG_WIDTH  (W),
    .SYNC_STAGES(2)
  ) dut (
    .S_AXI_ACLK   (aclk),
    .S_AXI_ARESETN(aresetn),
    .pins         (pins)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_sr, m_shadow;
  int         m_cnt, m_count;
  logic       m_lerr;
  logic [1:0] m_state;

  // Observations captured while driving one pin event
  int   obs_hits, obs_first;
  logic obs_out_pre, obs_out_post;

  task automatic m_clear_chain();
    m_sr = '0; m_shadow = '0; m_cnt = 0; m_lerr = 1'b0; m_state = 2'd0;
  endtask

  task automatic m_step(input logic do_clk, input logic do_load, input logic b);
    if (do_load) begin
      if (m_cnt != W) m_lerr = 1'b1;
      m_shadow = m_sr;
      m_cnt    = 0;
      if (m_count < 65535) m_count++;
      m_state  = 2'd0;
    end
    if (do_clk) begin
      m_sr = {m_sr[6:0], b};
      if (!do_load) begin
        if (m_cnt < W + 1) m_cnt++;
        m_state = (m_cnt >= W) ? 2'd2 : 2'd1;
      end
    end
  endtask

  // One pin event: data set a period ahead, strobes high 4 periods, low at least 5.
  task automatic drive_edge(input logic do_clk, input logic do_load, input logic b);
    obs_hits  = 0;
    obs_first = 0;
    @(posedge aclk); #1 pins.config_in = b;
    @(posedge aclk); #1;
    if (do_clk)  pins.config_clk  = 1'b1;
    if (do_load) pins.config_load = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(posedge aclk); @(negedge aclk);
      if (pins.load_pulse === 1'b1) begin
        obs_hits++;
        if (obs_first == 0) obs_first = j;
      end
      if (j == 2) obs_out_pre = pins.config_out;
      if (j == 3) obs_out_post = pins.config_out;
      if (j == 4) begin
        pins.config_clk  = 1'b0;
        pins.config_load = 1'b0;
      end
    end
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive_edge(1'b1, 1'b0, v[i]);
      m_step(1'b1, 1'b0, v[i]);
    end
  endtask

  task automatic do_load();
    drive_edge(1'b0, 1'b1, 1'b0);
    m_step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    pins.config_clk = 1'b0; pins.config_load = 1'b0; pins.config_in = 1'b0;
    pins.reset_not  = 1'b1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    m_clear_chain();
    m_count = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    pins.config_clk = 1'b0; pins.config_load = 1'b0; pins.config_in = 1'b0;
    pins.reset_not  = 1'b1;
    #12;
    total++; if (pins.config_out !== 1'b0)
      begin bad++; $display("FAIL reset_out got=%b want=0", pins.config_out); end
    total++; if (pins.config_shadow !== 8'h00)
      begin bad++; $display("FAIL reset_shadow got=%h want=00", pins.config_shadow); end
    total++; if (pins.load_pulse !== 1'b0)
      begin bad++; $display("FAIL reset_pulse got=%b want=0", pins.load_pulse); end
    total++; if (pins.load_count !== 16'h0000)
      begin bad++; $display("FAIL reset_count got=%h want=0000", pins.load_count); end
    total++; if (pins.length_error !== 1'b0)
      begin bad++; $display("FAIL reset_lerr got=%b want=0", pins.length_error); end
    total++; if (pins.state !== 2'd0)
      begin bad++; $display("FAIL reset_state got=%0d want=0", pins.state); end
    #3 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    m_clear_chain();
    m_count = 0;
  endtask

  task automatic test_basic_load();
    logic [7:0] frame;
    apply_reset();
    frame = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      drive_edge(1'b1, 1'b0, frame[i]);
      m_step(1'b1, 1'b0, frame[i]);
      if (i == 7) begin
        total++; if (pins.state !== 2'd1)
          begin bad++; $display("FAIL basic_state_shift got=%0d want=1", pins.state); end
      end
    end
    total++; if (pins.state !== 2'd2)
      begin bad++; $display("FAIL basic_state_full got=%0d want=2", pins.state); end
    do_load();
    total++; if (pins.config_shadow !== 8'hA5)
      begin bad++; $display("FAIL basic_shadow got=%h want=a5", pins.config_shadow); end
    total++; if (obs_hits !== 1)
      begin bad++; $display("FAIL basic_pulse_len got=%0d want=1", obs_hits); end
    total++; if (obs_first !== 3)
      begin bad++; $display("FAIL basic_pulse_cycle got=%0d want=3", obs_first); end
    total++; if (pins.load_count !== 16'd1)
      begin bad++; $display("FAIL basic_count got=%0d want=1", pins.load_count); end
    total++; if (pins.length_error !== 1'b0)
      begin bad++; $display("FAIL basic_lerr got=%b want=0", pins.length_error); end
    total++; if (pins.state !== 2'd0)
      begin bad++; $display("FAIL basic_state_idle got=%0d want=0", pins.state); end
  endtask

  task automatic test_serial_out();
    logic [7:0] second;
    logic       exp_pre, exp_post;
    apply_reset();
    shift_bits(16'h00A5, 8);
    second = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      exp_pre = m_sr[7];
      drive_edge(1'b1, 1'b0, second[i]);
      m_step(1'b1, 1'b0, second[i]);
      exp_post = m_sr[7];
      total++; if (obs_out_pre !== exp_pre)
        begin bad++; $display("FAIL serial_pre bit%0d got=%b want=%b", i, obs_out_pre, exp_pre); end
      total++; if (obs_out_post !== exp_post)
        begin bad++; $display("FAIL serial_post bit%0d got=%b want=%b", i, obs_out_post, exp_post); end
    end
    total++; if (pins.state !== 2'd2)
      begin bad++; $display("FAIL serial_state got=%0d want=2", pins.state); end
  endtask

  task automatic test_length_error();
    logic [4:0] short_bits;
    logic [7:0] frame;
    apply_reset();
    short_bits = 5'($urandom);
    shift_bits({11'd0, short_bits}, 5);
    do_load();
    total++; if (pins.length_error !== 1'b1)
      begin bad++; $display("FAIL len_err_set got=%b want=1", pins.length_error); end
    total++; if (pins.config_shadow !== {3'b000, short_bits})
      begin bad++; $display("FAIL len_shadow got=%h want=%h", pins.config_shadow, {3'b000, short_bits}); end
    frame = 8'($urandom);
    shift_bits({8'd0, frame}, 8);
    do_load();
    total++; if (pins.length_error !== 1'b1)
      begin bad++; $display("FAIL len_err_sticky got=%b want=1", pins.length_error); end
    total++; if (pins.config_shadow !== frame)
      begin bad++; $display("FAIL len_shadow2 got=%h want=%h", pins.config_shadow, frame); end
    @(posedge aclk); #1 pins.reset_not = 1'b0;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    m_clear_chain();
    total++; if (pins.length_error !== m_lerr)
      begin bad++; $display("FAIL len_err_clear got=%b want=%b", pins.length_error, m_lerr); end
    total++; if (pins.load_count !== 16'(m_count))
      begin bad++; $display("FAIL len_count_kept got=%0d want=%0d", pins.load_count, m_count); end
    total++; if (pins.config_shadow !== m_shadow)
      begin bad++; $display("FAIL len_shadow_clear got=%h want=%h", pins.config_shadow, m_shadow); end
    total++; if (pins.state !== 2'd0 || pins.config_out !== 1'b0)
      begin bad++; $display("FAIL len_chain_clear got=%0d/%b want=0/0", pins.state, pins.config_out); end
    pins.reset_not = 1'b1;
    repeat (4) @(posedge aclk);
  endtask

  task automatic test_simultaneous();
    logic [7:0] frame;
    apply_reset();
    shift_bits(16'h00FF, 8);
    drive_edge(1'b1, 1'b1, 1'b0);
    m_step(1'b1, 1'b1, 1'b0);
    total++; if (pins.config_shadow !== 8'hFF)
      begin bad++; $display("FAIL simul_shadow got=%h want=ff", pins.config_shadow); end
    total++; if (obs_hits !== 1)
      begin bad++; $display("FAIL simul_pulse got=%0d want=1", obs_hits); end
    total++; if (pins.state !== 2'd0)
      begin bad++; $display("FAIL simul_state got=%0d want=0", pins.state); end
    // Shifting the next frame out exposes the post-shift register and the cleared count.
    frame = 8'($urandom);
    for (int i = 7; i >= 0; i--) begin
      drive_edge(1'b1, 1'b0, frame[i]);
      m_step(1'b1, 1'b0, frame[i]);
      total++; if (obs_out_post !== m_sr[7])
        begin bad++; $display("FAIL simul_sr bit%0d got=%b want=%b", i, obs_out_post, m_sr[7]); end
    end
    do_load();
    total++; if (pins.length_error !== 1'b0)
      begin bad++; $display("FAIL simul_cnt_clear got=%b want=0", pins.length_error); end
    total++; if (pins.config_shadow !== frame)
      begin bad++; $display("FAIL simul_shadow2 got=%h want=%h", pins.config_shadow, frame); end
  endtask

  task automatic test_async_reset();
    logic [7:0] frame;
    apply_reset();
    frame = 8'($urandom) | 8'h80;
    shift_bits({8'd0, frame}, 8);
    do_load();
    shift_bits(16'h0005, 3);
    @(posedge aclk); #1 pins.config_in = 1'b1;
    @(posedge aclk); #1 pins.config_clk = 1'b1;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    total++; if ({pins.config_out, pins.load_pulse, pins.length_error} !== 3'b000)
      begin bad++; $display("FAIL areset_flags got=%b want=000",
                            {pins.config_out, pins.load_pulse, pins.length_error}); end
    total++; if (pins.config_shadow !== 8'h00 || pins.load_count !== 16'h0000)
      begin bad++; $display("FAIL areset_regs got=%h/%h want=00/0000",
                            pins.config_shadow, pins.load_count); end
    total++; if (pins.state !== 2'd0)
      begin bad++; $display("FAIL areset_state got=%0d want=0", pins.state); end
    pins.config_clk = 1'b0;
    #20 aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    m_clear_chain();
    m_count = 0;
    frame = 8'($urandom);
    shift_bits({8'd0, frame}, 8);
    do_load();
    total++; if (pins.config_shadow !== frame)
      begin bad++; $display("FAIL areset_frame got=%h want=%h", pins.config_shadow, frame); end
    total++; if (pins.length_error !== 1'b0 || pins.load_count !== 16'd1)
      begin bad++; $display("FAIL areset_after got=%b/%0d want=0/1",
                            pins.length_error, pins.load_count); end
  endtask

  task automatic test_release_high();
    logic [6:0] rest;
    aresetn = 1'b0;
    pins.config_load = 1'b0; pins.reset_not = 1'b1;
    pins.config_in = 1'b1; pins.config_clk = 1'b1;
    #23 aresetn = 1'b1;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    m_clear_chain();
    m_count = 0;
    m_step(1'b1, 1'b0, 1'b1);
    total++; if (pins.state !== m_state)
      begin bad++; $display("FAIL release_edge got=%0d want=%0d", pins.state, m_state); end
    pins.config_clk = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    total++; if (pins.state !== m_state)
      begin bad++; $display("FAIL release_single got=%0d want=%0d", pins.state, m_state); end
    rest = 7'($urandom);
    shift_bits({9'd0, rest}, 7);
    do_load();
    total++; if (pins.config_shadow !== {1'b1, rest})
      begin bad++; $display("FAIL release_shadow got=%h want=%h", pins.config_shadow, {1'b1, rest}); end
    total++; if (pins.length_error !== 1'b0)
      begin bad++; $display("FAIL release_lerr got=%b want=0", pins.length_error); end
  endtask

  task automatic test_random();
    int          len;
    logic [15:0] data;
    apply_reset();
    for (int it = 0; it < 10; it++) begin
      len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : W;
      data = 16'($urandom);
      shift_bits(data, len);
      total++; if (pins.config_out !== m_sr[7])
        begin bad++; $display("FAIL rand_out it%0d got=%b want=%b", it, pins.config_out, m_sr[7]); end
      do_load();
      total++; if (pins.config_shadow !== m_shadow)
        begin bad++; $display("FAIL rand_shadow it%0d got=%h want=%h", it, pins.config_shadow, m_shadow); end
      total++; if (pins.length_error !== m_lerr)
        begin bad++; $display("FAIL rand_lerr it%0d got=%b want=%b", it, pins.length_error, m_lerr); end
      total++; if (pins.load_count !== 16'(m_count) || obs_hits !== 1)
        begin bad++; $display("FAIL rand_count it%0d got=%0d/%0d want=%0d/1",
                              it, pins.load_count, obs_hits, m_count); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    // Preload the counter near saturation rather than issuing 65533 loads.
    @(negedge aclk);
    force dut.load_count_q = 16'hFFFD;
    @(posedge aclk); #1;
    release dut.load_count_q;
    m_count = 65533;
    @(negedge aclk);
    total++; if (pins.load_count !== 16'(m_count))
      begin bad++; $display("FAIL sat_preload got=%h want=%h", pins.load_count, 16'(m_count)); end
    for (int k = 0; k < 3; k++) begin
      do_load();
      total++; if (obs_hits !== 1)
        begin bad++; $display("FAIL sat_pulse load%0d got=%0d want=1", k, obs_hits); end
      total++; if (pins.load_count !== 16'(m_count))
        begin bad++; $display("FAIL sat_count load%0d got=%h want=%h", k, pins.load_count, 16'(m_count)); end
    end
    total++; if (pins.load_count !== 16'hFFFF)
      begin bad++; $display("FAIL sat_hold got=%h want=ffff", pins.load_count); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_serial_out();
    test_length_error();
    test_simultaneous();
    test_async_reset();
    test_release_high();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
